// File: rtl/exp6_unidade_controle_pkg.sv
// exp6_unidade_controle_pkg: state encodings shared by the memory-game control unit
package exp6_unidade_controle_pkg;
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    PREPARACAO     = 4'h1,
    INICIA_RODADA  = 4'h2,
    MOSTRA         = 4'h3,
    MOSTRA_PROXIMO = 4'h4,
    PREP_JOGADA    = 4'h5,
    ESPERA_JOGADA  = 4'h6,
    REGISTRA       = 4'h7,
    COMPARACAO     = 4'h8,
    PROXIMA_RODADA = 4'h9,
    FIM_ACERTOU    = 4'hA,
    PROXIMA_JOGADA = 4'hB,
    FIM_TIMEOUT    = 4'hC,
    FIM_ERROU      = 4'hE
  } estado_t;
  localparam logic [3:0] DB_ILEGAL = 4'hF;
endpackage

// File: rtl/exp6_unidade_controle.sv
// exp6_unidade_controle: Moore FSM sequencing display, player moves and game end
module exp6_unidade_controle
  import exp6_unidade_controle_pkg::*;
#(
  parameter bit HAS_TIMEOUT = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimE,
  input  logic       fimL,
  input  logic       fimT,
  input  logic       fimS,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraL,
  output logic       contaL,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraS,
  output logic       contaS,
  output logic       zeraR,
  output logic       registraR,
  output logic       mostraLed,
  output logic       timeout,
  output logic       errou,
  output logic       acertou,
  output logic       pronto,
  output logic [3:0] db_estado
);
  estado_t state_q, state_d;
  always_ff @(posedge clock or posedge reset)
    if (reset) state_q <= INICIAL;
    else       state_q <= state_d;
  always_comb begin
    state_d = INICIAL;
    case (state_q)
      INICIAL, FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU:
        state_d = iniciar ? PREPARACAO : state_q;
      PREPARACAO:     state_d = INICIA_RODADA;
      INICIA_RODADA:  state_d = MOSTRA;
      MOSTRA:         state_d = !fimS ? MOSTRA : fimE ? PREP_JOGADA : MOSTRA_PROXIMO;
      MOSTRA_PROXIMO: state_d = MOSTRA;
      PREP_JOGADA:    state_d = ESPERA_JOGADA;
      // a press in the same cycle as the timer expiring still counts as a move
      ESPERA_JOGADA:  state_d = jogada ? REGISTRA : (fimT && HAS_TIMEOUT) ? FIM_TIMEOUT : ESPERA_JOGADA;
      REGISTRA:       state_d = COMPARACAO;
      COMPARACAO:     state_d = !igual ? FIM_ERROU : (fimE && fimL) ? FIM_ACERTOU :
                                fimE ? PROXIMA_RODADA : PROXIMA_JOGADA;
      PROXIMA_RODADA: state_d = INICIA_RODADA;
      PROXIMA_JOGADA: state_d = ESPERA_JOGADA;
      default:        state_d = INICIAL;
    endcase
  end
  always_comb begin
    zeraE     = state_q inside {INICIAL, PREPARACAO, INICIA_RODADA, PREP_JOGADA};
    contaE    = state_q inside {MOSTRA_PROXIMO, PROXIMA_JOGADA};
    zeraL     = state_q inside {INICIAL, PREPARACAO};
    contaL    = state_q == PROXIMA_RODADA;
    zeraT     = state_q inside {INICIAL, PREPARACAO, PREP_JOGADA, PROXIMA_JOGADA};
    contaT    = state_q == ESPERA_JOGADA;
    zeraS     = state_q inside {INICIAL, PREPARACAO, INICIA_RODADA, MOSTRA_PROXIMO};
    contaS    = state_q == MOSTRA;
    zeraR     = state_q inside {INICIAL, PREPARACAO};
    registraR = state_q == REGISTRA;
    mostraLed = state_q == MOSTRA;
    timeout   = state_q == FIM_TIMEOUT;
    errou     = state_q == FIM_ERROU;
    acertou   = state_q == FIM_ACERTOU;
    pronto    = state_q inside {FIM_ACERTOU, FIM_TIMEOUT, FIM_ERROU};
    db_estado = state_q inside {INICIAL, PREPARACAO, INICIA_RODADA, MOSTRA, MOSTRA_PROXIMO,
                                PREP_JOGADA, ESPERA_JOGADA, REGISTRA, COMPARACAO, PROXIMA_RODADA,
                                FIM_ACERTOU, PROXIMA_JOGADA, FIM_TIMEOUT, FIM_ERROU}
                ? state_q : DB_ILEGAL;
  end
endmodule

// File: tb/tb_exp6_unidade_controle.sv
// tb_exp6_unidade_controle: directed vectors, corner sequences and random run vs a table model
module tb_exp6_unidade_controle;
  logic clock = 0, reset = 1;
  logic iniciar = 0, jogada = 0, igual = 0, fimE = 0, fimL = 0, fimT = 0, fimS = 0;
  logic [14:0] f1, f0;
  logic [3:0]  d1, d0;
  logic [18:0] o1, o0;
  int n_tests = 0, n_fail = 0;
  int s1, s0;
  logic [14:0] ref_out [16];
  localparam logic [6:0] I = 7'b1000000, J = 7'b0100000, G = 7'b0010000, E = 7'b0001000,
                         L = 7'b0000100, T = 7'b0000010, S = 7'b0000001, Z = 7'b0000000;
  typedef struct { logic [6:0] inp; int db; } vec_t;
  vec_t vt [19];

  always #5 clock = ~clock;

  exp6_unidade_controle #(.HAS_TIMEOUT(1'b1)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimE(fimE), .fimL(fimL), .fimT(fimT), .fimS(fimS),
    .zeraE(f1[14]), .contaE(f1[13]), .zeraL(f1[12]), .contaL(f1[11]), .zeraT(f1[10]),
    .contaT(f1[9]), .zeraS(f1[8]), .contaS(f1[7]), .zeraR(f1[6]), .registraR(f1[5]),
    .mostraLed(f1[4]), .timeout(f1[3]), .errou(f1[2]), .acertou(f1[1]), .pronto(f1[0]),
    .db_estado(d1));
  exp6_unidade_controle #(.HAS_TIMEOUT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada), .igual(igual),
    .fimE(fimE), .fimL(fimL), .fimT(fimT), .fimS(fimS),
    .zeraE(f0[14]), .contaE(f0[13]), .zeraL(f0[12]), .contaL(f0[11]), .zeraT(f0[10]),
    .contaT(f0[9]), .zeraS(f0[8]), .contaS(f0[7]), .zeraR(f0[6]), .registraR(f0[5]),
    .mostraLed(f0[4]), .timeout(f0[3]), .errou(f0[2]), .acertou(f0[1]), .pronto(f0[0]),
    .db_estado(d0));
  assign o1 = {f1, d1};
  assign o0 = {f0, d0};

  // Game rules as a transition function over state numbers
  function automatic int ref_next(int s, logic [6:0] v, bit ht);
    logic ini, jog, ig, fe, fl, ft, fs;
    {ini, jog, ig, fe, fl, ft, fs} = v;
    if (s == 0 || s == 10 || s == 12 || s == 14) return ini ? 1 : s;
    if (s == 3) return !fs ? 3 : (fe ? 5 : 4);
    if (s == 6) return jog ? 7 : ((ft && ht) ? 12 : 6);
    if (s == 8) return !ig ? 14 : ((fe && fl) ? 10 : (fe ? 9 : 11));
    if (s == 1 || s == 9) return 2;
    if (s == 2 || s == 4) return 3;
    if (s == 5 || s == 11) return 6;
    if (s == 7) return 8;
    return 0;
  endfunction

  function automatic logic [18:0] expv(int s);
    logic [3:0] c;
    c = s[3:0];
    return {ref_out[s], c};
  endfunction

  task automatic chk(input string nm, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_in(input logic [6:0] v);
    {iniciar, jogada, igual, fimE, fimL, fimT, fimS} = v;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    set_in(Z);
    reset = 1;
    #1;
    chk("reset_async", o1, expv(0));
    step();
    reset = 0;
    s1 = 0;
    s0 = 0;
  endtask

  task automatic go(input string nm, input logic [6:0] v, input int exp1, input int exp0);
    set_in(v);
    step();
    chk({nm, "_dut"}, o1, expv(exp1));
    chk({nm, "_dut0"}, o0, expv(exp0));
  endtask

  task automatic to_espera();
    do_reset();
    go("start1", I, 1, 1);
    go("start2", Z, 2, 2);
    go("start3", E, 3, 3);
    go("show", S | E, 5, 5);
    go("prep", Z, 6, 6);
  endtask

  initial begin
    ref_out[0]  = 15'b101010101000000;
    ref_out[1]  = 15'b101010101000000;
    ref_out[2]  = 15'b100000100000000;
    ref_out[3]  = 15'b000000010010000;
    ref_out[4]  = 15'b010000100000000;
    ref_out[5]  = 15'b100010000000000;
    ref_out[6]  = 15'b000001000000000;
    ref_out[7]  = 15'b000000000100000;
    ref_out[8]  = 15'b000000000000000;
    ref_out[9]  = 15'b000100000000000;
    ref_out[10] = 15'b000000000000011;
    ref_out[11] = 15'b010010000000000;
    ref_out[12] = 15'b000000000001001;
    ref_out[13] = 15'b000000000000000;
    ref_out[14] = 15'b000000000000101;
    ref_out[15] = 15'b000000000000000;
    vt[0]  = '{I, 1};         vt[1]  = '{Z, 2};         vt[2]  = '{E, 3};
    vt[3]  = '{S | E, 5};     vt[4]  = '{E, 6};         vt[5]  = '{J | G | E, 7};
    vt[6]  = '{G | E, 8};     vt[7]  = '{G | E, 9};     vt[8]  = '{I, 2};
    vt[9]  = '{Z, 3};         vt[10] = '{S, 4};         vt[11] = '{I, 3};
    vt[12] = '{S | E, 5};     vt[13] = '{Z, 6};         vt[14] = '{J, 7};
    vt[15] = '{Z, 8};         vt[16] = '{Z, 14};        vt[17] = '{Z, 14};
    vt[18] = '{I, 1};

    do_reset();
    chk("reset_state", o1, expv(0));
    for (int i = 0; i < 19; i++) begin
      set_in(vt[i].inp);
      step();
      chk($sformatf("vec%0d", i), o1, expv(vt[i].db));
    end

    // asynchronous reset in the middle of the display phase
    do_reset();
    go("a1", I, 1, 1);
    go("a2", Z, 2, 2);
    go("a3", Z, 3, 3);
    #2;
    reset = 1;
    #1;
    chk("reset_mid_mostra", o1, expv(0));
    step();
    reset = 0;
    go("a4", I, 1, 1);
    go("a5", Z, 2, 2);
    go("a6", Z, 3, 3);

    to_espera();
    go("timeout", T, 12, 6);
    go("timeout_hold", T, 12, 6);
    go("timeout_restart", I, 1, 6);

    to_espera();
    go("jog_beats_t", J | T, 7, 7);

    to_espera();
    go("last_reg", J | G | E | L, 7, 7);
    go("last_cmp", G | E | L, 8, 8);
    go("last_win", G | E | L, 10, 10);
    go("win_hold", Z, 10, 10);
    go("win_restart", I, 1, 1);

    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [6:0] v;
      int n1, n0;
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
        continue;
      end
      v = {$urandom_range(0, 9) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 5) != 0,
           1'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) == 0};
      n1 = ref_next(s1, v, 1'b1);
      n0 = ref_next(s0, v, 1'b0);
      set_in(v);
      step();
      s1 = n1;
      s0 = n0;
      chk("rand_dut", o1, expv(s1));
      chk("rand_dut0", o0, expv(s0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/exp6_unidade_controle.md
# exp6_unidade_controle

Moore control unit for the round-based memory game, where each round adds one step to the sequence. Each round it first shows the stored sequence on the LEDs, entry 0 up to the current round limit. It then waits for the player to repeat that prefix, with a per-move timeout. It sits beside the datapath and drives:

- the address counter (E),
- the round counter (L),
- the move timer (T),
- the display timer (S),
- the move register (R).

It consumes the datapath's comparator and end-of-count flags.

## Interface
Parameters:
- HAS_TIMEOUT, 1, when 0 the fimT input is ignored and no timeout ending is possible

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high; forces state inicial
- iniciar  in  1  start or restart request
- jogada  in  1  one-cycle pulse for a player button press (edge-detected by the datapath)
- igual  in  1  registered move equals memory[E]
- fimE  in  1  address counter E equals round counter L
- fimL  in  1  round counter L is at its last round
- fimT  in  1  move timer expired
- fimS  in  1  display timer expired (one LED step finished)
- zeraE, contaE  out  1  clear / increment the address counter
- zeraL, contaL  out  1  clear / increment the round counter
- zeraT, contaT  out  1  clear / enable the move timer
- zeraS, contaS  out  1  clear / enable the display timer
- zeraR, registraR  out  1  clear / load the move register
- mostraLed  out  1  datapath drives LEDs from memory[E]
- timeout, errou, acertou, pronto  out  1  end-of-game flags
- db_estado  out  4  current state code

## Operation
State codes, with transitions (each state lists the flags not mentioned as low):
- inicial 0
  - iniciar → preparacao, else stay.
  - Asserts zeraE, zeraL, zeraT, zeraS and zeraR.
- preparacao 1
  - → inicia_rodada.
  - Asserts zeraE, zeraL, zeraT, zeraS and zeraR.
- inicia_rodada 2
  - → mostra.
  - Asserts zeraE and zeraS.
- mostra 3
  - Asserts mostraLed and contaS.
  - When fimS is high: fimE → prep_jogada, else → mostra_proximo. When fimS is low, stay.
- mostra_proximo 4
  - → mostra.
  - Asserts contaE and zeraS.
- prep_jogada 5
  - → espera_jogada.
  - Asserts zeraE and zeraT.
- espera_jogada 6
  - Asserts contaT.
  - jogada → registra.
  - Else (fimT & HAS_TIMEOUT) → fim_timeout.
  - Else stay.
- registra 7
  - → comparacao.
  - Asserts registraR.
- comparacao 8, evaluated in priority order:
  - ~igual → fim_errou.
  - fimE & fimL → fim_acertou.
  - fimE → proxima_rodada.
  - Else → proxima_jogada.
- proxima_rodada 9
  - → inicia_rodada.
  - Asserts contaL.
- proxima_jogada B
  - → espera_jogada.
  - Asserts contaE and zeraT.
- fim_acertou A
  - Asserts acertou and pronto.
- fim_timeout C
  - Asserts timeout and pronto.
- fim_errou E
  - Asserts errou and pronto.
- All three end states: iniciar → preparacao, else stay.
- Code D is unused. Any illegal state → inicial, with db_estado = F while in it.

Other rules:
- All outputs are purely decoded from the current state; no input reaches an output combinationally.
- iniciar is ignored in every state other than inicial and the three end states.

## Timing
- Reset:
  - Takes effect immediately and asynchronously, including mid-round.
  - Output values during and after reset are those of inicial: zeraE, zeraL, zeraT, zeraS and zeraR high, all other outputs 0, db_estado = 0.
- Start latency:
  - iniciar sampled high in inicial → preparacao at +1, inicia_rodada at +2.
  - mostraLed first high at +3.
- Display cost:
  - Each LED step lasts (cycles mostra waits for fimS) + 1 cycle in mostra_proximo. The final step has no mostra_proximo.
  - prep_jogada adds one cycle before the player may move.
- Move latency:
  - jogada high in espera_jogada → registra at +1, comparacao at +2.
  - Result state (end state, proxima_rodada or proxima_jogada) at +3.
- Simultaneous jogada and fimT in espera_jogada: jogada wins.
- jogada outside espera_jogada is dropped.
- The move timer is cleared for every move, via prep_jogada and proxima_jogada.

## Structure
- The shared package holds:
  - the 4-bit state encodings listed above;
  - the debug code F for illegal states.
- The unit is a single module: a state register, a next-state case and an output decode.
- No sub-module is needed.

## Test plan
- Reset while in mostra → state 0 and zeraE = zeraL = 1 within the same cycle. Release, then pulse iniciar → db_estado sequence 1, 2, 3.
- Round 0 (fimE high from the start):
  - fimS pulse → 5, 6.
  - jogada with igual = 1, fimL = 0 → 7, 8, 9, 2, with contaL high for exactly one cycle.
- Round 1, two-step display: fimE low for the first step → states 3, 4, 3 with contaE high once. Then fimE high with fimS → 5.
- Wrong move: in state 6, jogada with igual = 0 → 7, 8, E. errou and pronto stay high until iniciar → 1.
- Timeout:
  - HAS_TIMEOUT = 1: fimT in 6 → C with timeout = 1.
  - Same cycle as jogada → 7 instead.
  - HAS_TIMEOUT = 0: fimT held in 6 → remains 6.
- Last round, final move: igual = fimE = fimL = 1 → A with acertou = pronto = 1. iniciar → 1, with zeraL asserted.
